minicpu_sequencer: RTL and testbench

Program sequencer in front of the MiniCPU datapath. It buffers a short program of 12-bit instruction words ({command[3:0], operand[7:0]}) loaded over a valid/ready port. On START it issues the words to the datapath one per clock and tracks in-flight words through the datapath's result latency. It captures the final RESULT, and optionally aborts on OVERFLOW. It sits between the host/test driver and MiniCPU's `IN`/`RESULT`/`OVERFLOW` pins.

---
 rtl/minicpu_pkg.sv | 26 ++
 rtl/seq_prog_buf.sv | 43 ++++
 rtl/minicpu_sequencer.sv | 155 +++++++++++++++
 tb/tb_minicpu_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/minicpu_pkg.sv
// Shared constants, state type and instruction field helpers for the MiniCPU
// program sequencer.
package minicpu_pkg;

    localparam int CMD_W   = 4;
    localparam int NUM_W   = 8;
    localparam int INSTR_W = CMD_W + NUM_W;

    localparam logic [CMD_W-1:0]   CMD_NOP   = 4'h0;
    localparam logic [INSTR_W-1:0] INSTR_NOP = {CMD_NOP, {NUM_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } seq_state_e;

    function automatic logic [CMD_W-1:0] instr_cmd(input logic [INSTR_W-1:0] w);
        return w[INSTR_W-1:NUM_W];
    endfunction

    function automatic logic [NUM_W-1:0] instr_num(input logic [INSTR_W-1:0] w);
        return w[NUM_W-1:0];
    endfunction

endpackage

// File: rtl/seq_prog_buf.sv
// Program buffer: DEPTH x INSTR_W register array, written in order at count,
// read asynchronously at the sequencer's program counter.
module seq_prog_buf
    import minicpu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [INSTR_W-1:0]       wr_data,
    input  logic                     clr,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [INSTR_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Contents survive reset; they become unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wr_en && !full) begin
            count <= count + 1'b1;
        end
    end

    assign rd_data = mem[rd_addr];
    assign full    = count[AW];

endmodule

// File: rtl/minicpu_sequencer.sv
// Program sequencer for MiniCPU: buffers a short program, issues it one word
// per clock, tracks words through the datapath latency and captures the result.
module minicpu_sequencer
    import minicpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LAT   = 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     LOAD_VALID,
    input  logic [INSTR_W-1:0]       LOAD_DATA,
    output logic                     LOAD_READY,
    input  logic                     START,
    input  logic                     HALT_ON_OVF,
    output logic [INSTR_W-1:0]       CPU_IN,
    input  logic [NUM_W-1:0]         CPU_RESULT,
    input  logic                     CPU_OVERFLOW,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ERR,
    output logic [NUM_W-1:0]         FINAL_RESULT,
    output logic [$clog2(DEPTH)-1:0] PC
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PC_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    seq_state_e         state;
    logic [INSTR_W-1:0] cpu_in_p0;
    logic [LAT:0]       vld_trk;
    logic [AW-1:0]      pc_q;
    logic               halt_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [NUM_W-1:0]   final_q;

    logic               hs;
    logic               full;
    logic               buf_clr;
    logic [AW:0]        count;
    logic [AW:0]        load_cnt;
    logic [AW-1:0]      rd_addr;
    logic [INSTR_W-1:0] rd_data;
    logic [INSTR_W-1:0] first_word;
    logic               start_go;
    logic               ovf_abort;
    logic               drain_done;
    logic               last_issue;

    seq_prog_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (CLK),
        .rst_n   (RST_N),
        .wr_en   (hs),
        .wr_data (LOAD_DATA),
        .clr     (buf_clr),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .count   (count),
        .full    (full)
    );

    // Decoded from registered state only, so no input reaches it combinationally.
    assign LOAD_READY = (state == IDLE) && !full;
    assign hs         = LOAD_VALID && LOAD_READY;
    assign load_cnt   = count + {{AW{1'b0}}, hs};
    assign start_go   = (state == IDLE) && START && (load_cnt != '0);

    // Word 0 goes out on the START edge; an empty buffer means it is being loaded now.
    assign rd_addr    = (state == IDLE) ? '0 : pc_q;
    assign first_word = (count == '0) ? LOAD_DATA : rd_data;

    // vld_trk[0] is aligned with CPU_IN; vld_trk[LAT] marks a real word's effect.
    assign ovf_abort  = (state != IDLE) && halt_q && vld_trk[LAT] && CPU_OVERFLOW;
    assign drain_done = (state == DRAIN) && vld_trk[LAT] && (vld_trk[LAT-1:0] == '0);
    assign last_issue = ({1'b0, pc_q} == (count - 1'b1));
    assign buf_clr    = ovf_abort || drain_done;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            cpu_in_p0 <= INSTR_NOP;
            vld_trk   <= '0;
            pc_q      <= '0;
            halt_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            final_q   <= '0;
        end else begin
            done_q    <= 1'b0;
            cpu_in_p0 <= INSTR_NOP;
            vld_trk   <= {vld_trk[LAT-1:0], 1'b0};
            case (state)
                IDLE: begin
                    if (start_go) begin
                        err_q     <= 1'b0;
                        halt_q    <= HALT_ON_OVF;
                        busy_q    <= 1'b1;
                        cpu_in_p0 <= first_word;
                        vld_trk   <= {vld_trk[LAT-1:0], 1'b1};
                        pc_q      <= PC_ONE;
                        state     <= (load_cnt == CNT_ONE) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (ovf_abort) begin
                        final_q <= CPU_RESULT;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        vld_trk <= '0;
                        state   <= IDLE;
                    end else begin
                        cpu_in_p0 <= rd_data;
                        vld_trk   <= {vld_trk[LAT-1:0], 1'b1};
                        pc_q      <= pc_q + 1'b1;
                        if (last_issue) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (ovf_abort) begin
                        final_q <= CPU_RESULT;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        vld_trk <= '0;
                        state   <= IDLE;
                    end else if (drain_done) begin
                        final_q <= CPU_RESULT;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        vld_trk <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign CPU_IN       = cpu_in_p0;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ERR          = err_q;
    assign FINAL_RESULT = final_q;
    assign PC           = pc_q;

endmodule

// File: tb/tb_minicpu_sequencer.sv
// Directed bench for minicpu_sequencer (DEPTH=16, LAT=1); the bench plays the
// MiniCPU by driving CPU_RESULT / CPU_OVERFLOW cycle by cycle.
module tb_minicpu_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        LOAD_VALID = 1'b0;
    logic [11:0] LOAD_DATA = '0;
    logic        LOAD_READY;
    logic        START = 1'b0;
    logic        HALT_ON_OVF = 1'b0;
    logic [11:0] CPU_IN;
    logic [7:0]  CPU_RESULT = '0;
    logic        CPU_OVERFLOW = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [7:0]  FINAL_RESULT;
    logic [3:0]  PC;

    int n_chk = 0;
    int n_bad = 0;

    minicpu_sequencer #(
        .DEPTH (16),
        .LAT   (1)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .LOAD_VALID   (LOAD_VALID),
        .LOAD_DATA    (LOAD_DATA),
        .LOAD_READY   (LOAD_READY),
        .START        (START),
        .HALT_ON_OVF  (HALT_ON_OVF),
        .CPU_IN       (CPU_IN),
        .CPU_RESULT   (CPU_RESULT),
        .CPU_OVERFLOW (CPU_OVERFLOW),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .ERR          (ERR),
        .FINAL_RESULT (FINAL_RESULT),
        .PC           (PC)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_rst(input string p);
        chk({p, "_cpu_in"}, CPU_IN, 0);
        chk({p, "_ready"}, LOAD_READY, 1);
        chk({p, "_busy"}, BUSY, 0);
        chk({p, "_done"}, DONE, 0);
        chk({p, "_err"}, ERR, 0);
        chk({p, "_final"}, FINAL_RESULT, 0);
        chk({p, "_pc"}, PC, 0);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [11:0] w);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = w;
        step();
        LOAD_VALID = 1'b0;
    endtask

    // START is high in cycle 0; returns at the start of cycle 1.
    task automatic start_run(input logic h);
        START       = 1'b1;
        HALT_ON_OVF = h;
        step();
        START       = 1'b0;
        HALT_ON_OVF = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;

        #2 RST_N = 1'b0;
        #1 chk_rst("rst");
        @(negedge CLK) RST_N = 1'b1;
        step();

        // 3-word program, result 0x2A on the last word's effect cycle
        load(12'h105);
        load(12'h203);
        load(12'h101);
        start_run(1'b0);
        for (int c = 1; c <= 6; c++) begin
            CPU_RESULT = (c == 4) ? 8'h2A : 8'h00;
            @(negedge CLK);
            case (c)
                1: chk("t1_cpu_in_c1", CPU_IN, 12'h105);
                2: chk("t1_cpu_in_c2", CPU_IN, 12'h203);
                3: chk("t1_cpu_in_c3", CPU_IN, 12'h101);
                default: chk("t1_cpu_in_nop", CPU_IN, 12'h000);
            endcase
            chk("t1_done", DONE, (c == 5));
            chk("t1_busy", BUSY, (c <= 4));
            chk("t1_ready", LOAD_READY, (c >= 5));
            if (c == 5) begin
                chk("t1_final", FINAL_RESULT, 8'h2A);
                chk("t1_err", ERR, 0);
                chk("t1_pc", PC, 3);
            end
            step();
        end
        CPU_RESULT = 8'h00;
        chk("t1_final_hold", FINAL_RESULT, 8'h2A);

        // 8 words, HALT_ON_OVF=1, overflow on the second word's effect (cycle 3)
        for (int i = 0; i < 8; i++) load(12'h300 + 12'(i));
        start_run(1'b1);
        for (int c = 1; c <= 7; c++) begin
            CPU_OVERFLOW = (c == 3);
            CPU_RESULT   = (c == 3) ? 8'h77 : 8'h11;
            @(negedge CLK);
            chk("t3_cpu_in", CPU_IN, (c <= 3) ? (12'h300 + 12'(c - 1)) : 12'h000);
            chk("t3_done", DONE, (c == 4));
            chk("t3_err", ERR, (c >= 4));
            if (c == 4) begin
                chk("t3_final", FINAL_RESULT, 8'h77);
                chk("t3_pc", PC, 3);
                chk("t3_busy", BUSY, 0);
            end
            step();
        end
        CPU_OVERFLOW = 1'b0;

        // Same program with HALT_ON_OVF=0: overflow ignored
        for (int i = 0; i < 8; i++) load(12'h300 + 12'(i));
        start_run(1'b0);
        for (int c = 1; c <= 11; c++) begin
            CPU_OVERFLOW = (c == 3);
            CPU_RESULT   = (c == 9) ? 8'h55 : 8'h11;
            @(negedge CLK);
            chk("t4_cpu_in", CPU_IN, (c <= 8) ? (12'h300 + 12'(c - 1)) : 12'h000);
            chk("t4_done", DONE, (c == 10));
            chk("t4_err", ERR, 0);
            if (c == 10) begin
                chk("t4_final", FINAL_RESULT, 8'h55);
                chk("t4_pc", PC, 8);
            end
            step();
        end
        CPU_OVERFLOW = 1'b0;
        CPU_RESULT   = 8'h00;

        // Load and START in the same cycle on an empty buffer
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 12'h1AB;
        START      = 1'b1;
        @(negedge CLK);
        chk("t5_ready_c0", LOAD_READY, 1);
        step();
        LOAD_VALID = 1'b0;
        START      = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            CPU_RESULT = (c == 2) ? 8'h3C : 8'h00;
            @(negedge CLK);
            chk("t5_cpu_in", CPU_IN, (c == 1) ? 12'h1AB : 12'h000);
            chk("t5_done", DONE, (c == 3));
            if (c == 3) begin
                chk("t5_final", FINAL_RESULT, 8'h3C);
                chk("t5_pc", PC, 1);
            end
            step();
        end

        // START with an empty buffer and no load: nothing happens
        start_run(1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            chk("t5e_busy", BUSY, 0);
            chk("t5e_done", DONE, 0);
            chk("t5e_cpu_in", CPU_IN, 0);
            step();
        end

        // Fill with LOAD_VALID held for 20 cycles: only 16 accepted
        acc = 0;
        LOAD_VALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            LOAD_DATA = 12'h400 + 12'(i);
            @(negedge CLK);
            if (LOAD_READY) acc++;
            step();
        end
        LOAD_VALID = 1'b0;
        @(negedge CLK);
        chk("t2_accepted", acc, 16);
        chk("t2_ready_full", LOAD_READY, 0);
        step();
        start_run(1'b0);
        for (int c = 1; c <= 18; c++) begin
            CPU_RESULT = (c == 17) ? 8'h99 : 8'h00;
            @(negedge CLK);
            if (c == 1 || c == 16 || c == 17)
                chk("t2_cpu_in", CPU_IN, (c <= 16) ? (12'h400 + 12'(c - 1)) : 12'h000);
            chk("t2_done", DONE, (c == 18));
            if (c == 18) begin
                chk("t2_final", FINAL_RESULT, 8'h99);
                chk("t2_pc", PC, 0);
            end
            step();
        end
        CPU_RESULT = 8'h00;

        // Asynchronous reset during RUN cycle 2
        for (int i = 0; i < 4; i++) load(12'h500 + 12'(i));
        start_run(1'b0);
        step();
        #2 RST_N = 1'b0;
        #1 chk_rst("t6_rst");
        @(negedge CLK) RST_N = 1'b1;
        step();
        start_run(1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            chk("t6_busy", BUSY, 0);
            chk("t6_done", DONE, 0);
            chk("t6_cpu_in", CPU_IN, 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
